uart_tx: RTL



---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel-side and line-side signal bundle for uart_tx
`timescale 1ns/1ps
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame serializer, one bit per baud clock
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q;
  logic                  tx_q;
  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q;
  logic                  par_typ_q;
`else
  logic                  unused_par;
  assign unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  assign cnt_d = cnt_q + CNT_W'(1);

  // Outputs are loaded with the value of the state being entered, so each
  // frame bit is on the line from the same edge that enters its state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.DATA_VALID && !busy_q) begin
            data_q    <= bus.P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
`endif
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          state_q <= DATA;
          cnt_q   <= '0;
          tx_q    <= data_q[0];
        end
        DATA: begin
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= (^data_q) ^ par_typ_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_d;
            tx_q  <= data_q[cnt_d];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.BUSY   = busy_q;
endmodule
